wb_burst_master: RTL

//  Wishbone initiator that turns commands from a valid/ready port into single or incrementing-burst
//  bus transfers, one beat outstanding. Each beat returns through a valid/ready response port.

---
 rtl/wb_burst_master.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone initiator. Commands arriving on a valid/ready port become a single
// transfer or an incrementing burst with exactly one beat outstanding. Every
// beat returns one response on a valid/ready port. Classic slaves (PIPED = 0)
// see stb held until ack. Pipelined slaves (PIPED = 1) see a one-cycle stb
// pulse per beat. A bus timeout ends a hung beat with an error response and
// abandons the rest of the command.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o          command handshake
//   cmd_we_i, cmd_adr_i                direction and start address
//   cmd_len_i                          beats - 1
//   cmd_dat_i                          write data, reused on every beat
//   res_valid_o / res_ready_i          response handshake
//   res_dat_o, res_err_o, res_last_o   read data, timeout flag, final beat
//   busy_o                             command in progress
//   cyc_o, stb_o, we_o, adr_o, dat_o   Wishbone initiator outputs
//   ack_i, dat_i                       Wishbone slave returns
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module wb_burst_master #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ABITS = 4,
    parameter int unsigned LBITS = 4,
    parameter bit          PIPED = 1'b0,
    parameter int unsigned TICKS = 15,
    parameter int unsigned DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // command port
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ABITS-1:0] cmd_adr_i,
    input  logic [LBITS-1:0] cmd_len_i,
    input  logic [WIDTH-1:0] cmd_dat_i,
    // response port
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_dat_o,
    output logic             res_err_o,
    output logic             res_last_o,
    output logic             busy_o,
    // Wishbone
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ABITS-1:0] adr_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] dat_i
);

    localparam int unsigned TBITS = (TICKS < 2) ? 1 : $clog2(TICKS + 1);
    // The beat times out on the edge that ends its TICKS-th ack-less cycle,
    // i.e. while the counter still holds TICKS-1.
    localparam logic [TBITS-1:0] TickLast = TBITS'(TICKS - 1);

    // DELAY is only meaningful to behavioural models that put #-delays on
    // outputs; this implementation is zero-delay.
    if (DELAY > 0) begin : g_zero_delay_rtl
    end

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StWait,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [ABITS-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_dat_q, res_dat_d;
    logic               res_err_q, res_err_d;
    logic               res_last_q, res_last_d;
    logic [LBITS-1:0]   beats_q, beats_d;
    logic [TBITS-1:0]   tick_q, tick_d;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        res_valid_d = res_valid_q;
        res_dat_d   = res_dat_q;
        res_err_d   = res_err_q;
        res_last_d  = res_last_q;
        beats_d     = beats_q;
        tick_d      = tick_q;

        unique case (state_q)
            StIdle: begin
                // cmd_ready rises on the first edge after reset release.
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = cmd_we_i;
                    adr_d       = cmd_adr_i;
                    dat_d       = cmd_dat_i;
                    beats_d     = cmd_len_i;
                    tick_d      = '0;
                    state_d     = StBus;
                end
            end

            StBus, StWait: begin
                // cyc_o is always high here, so ack_i with cyc_o low never
                // reaches this branch. Ack beats a simultaneous timeout.
                if (ack_i && cyc_q) begin
                    stb_d       = 1'b0;
                    cyc_d       = (beats_q != '0);
                    res_valid_d = 1'b1;
                    res_dat_d   = dat_i;
                    res_err_d   = 1'b0;
                    res_last_d  = (beats_q == '0);
                    state_d     = StResp;
                end else if (tick_q == TickLast) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    res_valid_d = 1'b1;
                    res_dat_d   = '0;
                    res_err_d   = 1'b1;
                    res_last_d  = 1'b1;
                    state_d     = StResp;
                end else begin
                    tick_d = tick_q + 1'b1;
                    if (PIPED && (state_q == StBus)) begin
                        stb_d   = 1'b0;
                        state_d = StWait;
                    end
                end
            end

            StResp: begin
                // The next beat waits for the response to be taken.
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (res_last_q) begin
                        cmd_ready_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        adr_d   = adr_q + 1'b1;
                        beats_d = beats_q - 1'b1;
                        stb_d   = 1'b1;
                        tick_d  = '0;
                        state_d = StBus;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            res_valid_q <= 1'b0;
            res_dat_q   <= '0;
            res_err_q   <= 1'b0;
            res_last_q  <= 1'b0;
            beats_q     <= '0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            res_valid_q <= res_valid_d;
            res_dat_q   <= res_dat_d;
            res_err_q   <= res_err_d;
            res_last_q  <= res_last_d;
            beats_q     <= beats_d;
            tick_q      <= tick_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign res_valid_o = res_valid_q;
    assign res_dat_o   = res_dat_q;
    assign res_err_o   = res_err_q;
    assign res_last_o  = res_last_q;

endmodule
